// File: rtl/ss_pkg.sv
// Shared constants for the seven-segment scan controller.
// Segment patterns are active-high, bit0=a .. bit6=g.
package ss_pkg;

    localparam logic [6:0] SEG_OFF = 7'h00;

    // Prescaler value on which anodes are held off between slots
    localparam int GUARD_PRESC = 0;

    localparam logic [6:0] SEG_PAT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to seven-segment pattern decoder.
// Purely a table lookup into the shared pattern constants.
module seg7_decode
    import ss_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_PAT[nib];

endmodule

// File: rtl/ss_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-synchronous value update.
// Define SS_LZB_EN to enable leading-zero blanking.
module ss_scan_ctrl
    import ss_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic                    ready,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = $clog2(REFRESH_DIV);

    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] disp;
    logic [4*NUM_DIGITS-1:0] pend;
    logic                    pend_v;

    logic                    tc;
    logic                    fb;
    logic [3:0]              nib;
    logic [6:0]              dec_seg;
    logic                    lzb;
    logic                    blank;
    logic [6:0]              seg_nxt;
    logic [NUM_DIGITS-1:0]   an_nxt;

    assign tc    = (presc == PW'(REFRESH_DIV - 1));
    assign fb    = tc && (idx == IW'(NUM_DIGITS - 1));
    assign nib   = disp[{idx, 2'b00} +: 4];
    assign ready = ~pend_v;

    seg7_decode u_dec (
        .nib (nib),
        .seg (dec_seg)
    );

`ifdef SS_LZB_EN
    logic [IW-1:0] msd;

    // Highest nonzero nibble; digit 0 stays lit even for an all-zero value
    always_comb begin
        msd = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (disp[4*i +: 4] != 4'h0) msd = IW'(i);
        end
    end

    assign lzb = (idx > msd);
`else
    assign lzb = 1'b0;
`endif

    assign blank = blank_mask[idx] | lzb;

    always_comb begin
        seg_nxt = dec_seg;
        an_nxt  = '0;
        if (blank) seg_nxt = SEG_OFF;
        if (presc != PW'(GUARD_PRESC)) begin
            an_nxt = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc      <= '0;
            idx        <= '0;
            disp       <= '0;
            pend       <= '0;
            pend_v     <= 1'b0;
            seg        <= SEG_OFF;
            an         <= '0;
            frame_tick <= 1'b0;
        end else begin
            presc      <= tc ? '0 : presc + 1'b1;
            seg        <= seg_nxt;
            an         <= an_nxt;
            frame_tick <= fb;
            if (tc) begin
                idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end
            // A load landing on the boundary bypasses pending (latest wins)
            if (fb) begin
                pend_v <= 1'b0;
                if (load)        disp <= value;
                else if (pend_v) disp <= pend;
            end else if (load) begin
                pend   <= value;
                pend_v <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ss_scan_ctrl.sv
// Randomised scoreboard bench for ss_scan_ctrl (NUM_DIGITS=4, REFRESH_DIV=8).
// Expected outputs come from a cycle-count based reference model.
module tb_ss_scan_ctrl;

    localparam int N   = 4;
    localparam int DIV = 8;

    typedef struct {
        logic [6:0]   seg;
        logic [N-1:0] an;
        logic         rdy;
        logic         ft;
        int           cyc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           load;
    logic [4*N-1:0] value;
    logic [N-1:0]   blank_mask;
    logic           ready;
    logic [6:0]     seg;
    logic [N-1:0]   an;
    logic           frame_tick;

    ss_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .blank_mask (blank_mask),
        .ready      (ready),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    logic [6:0] pat [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    exp_t           q [$];
    int             n_chk  = 0;
    int             n_pass = 0;
    int             cyc    = 0;

    // Reference model: time since reset plus the values the user asked for
    int             m_t    = 0;
    logic [4*N-1:0] m_disp = '0;
    logic [4*N-1:0] m_pend = '0;
    bit             m_pv   = 1'b0;
    logic [N-1:0]   mask   = '0;

    function automatic logic [6:0] ref_seg(logic [4*N-1:0] d, int i,
                                           logic [N-1:0] bm);
        int msd;
        logic [3:0] nb;
        msd = 0;
        for (int k = 0; k < N; k++) begin
            nb = d[4*k +: 4];
            if (nb != 0) msd = k;
        end
        nb = d[4*i +: 4];
        if (bm[i]) return 7'h00;
`ifdef SS_LZB_EN
        if (i > msd) return 7'h00;
`endif
        return pat[nb];
    endfunction

    task automatic step(input bit r, input bit ld, input logic [4*N-1:0] v);
        exp_t e;
        int p, i;
        bit f;
        @(negedge clk);
        rst_n      = r;
        load       = ld;
        value      = v;
        blank_mask = mask;
        cyc++;
        e.cyc = cyc;
        if (!r) begin
            e.seg = 7'h00; e.an = '0; e.ft = 1'b0; e.rdy = 1'b1;
            m_t = 0; m_disp = '0; m_pend = '0; m_pv = 1'b0;
        end else begin
            p = m_t % DIV;
            i = (m_t / DIV) % N;
            f = (p == DIV - 1) && (i == N - 1);
            e.an  = (p == 0) ? '0 : N'(1 << i);
            e.seg = ref_seg(m_disp, i, mask);
            e.ft  = f;
            if (f) begin
                if (ld)        m_disp = v;
                else if (m_pv) m_disp = m_pend;
                m_pv = 1'b0;
            end else if (ld) begin
                m_pend = v;
                m_pv   = 1'b1;
            end
            e.rdy = !m_pv;
            m_t++;
        end
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, '0);
    endtask

    // Advance until the next driven cycle sits at frame position pos
    task automatic to_pos(input int pos);
        while ((m_t % (N*DIV)) != pos) step(1'b1, 1'b0, '0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                n_chk++;
                if (seg === e.seg && an === e.an &&
                    ready === e.rdy && frame_tick === e.ft) begin
                    n_pass++;
                end else begin
                    $display("FAIL cyc%0d seg/an/ready/frame_tick got %h/%b/%b/%b want %h/%b/%b/%b",
                             e.cyc, seg, an, ready, frame_tick,
                             e.seg, e.an, e.rdy, e.ft);
                end
            end
        end
    end

    initial begin : stim
        int wait_cnt;
        rst_n = 1'b0; load = 1'b0; value = '0; blank_mask = '0;
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, '0);
        idle(70);
        // Deferred load, then load ignored-while-reset never occurs here
        to_pos(10);
        step(1'b1, 1'b1, 16'h12AF);
        idle(70);
        // Two loads in one frame: latest wins
        to_pos(5);
        step(1'b1, 1'b1, 16'h1111);
        idle(3);
        step(1'b1, 1'b1, 16'h2222);
        idle(60);
        // Load on the frame boundary goes straight to the display
        to_pos(N*DIV - 1);
        step(1'b1, 1'b1, 16'h5A3C);
        idle(40);
        // Live blank mask
        mask = 4'b0100;
        idle(40);
        mask = '0;
        to_pos(N*DIV - 1);
        step(1'b1, 1'b1, 16'h0005);
        idle(40);
        to_pos(N*DIV - 1);
        step(1'b1, 1'b1, 16'h0000);
        idle(40);
        // Mid-scan reset with a pending value and a load during reset
        to_pos(4);
        step(1'b1, 1'b1, 16'hBEEF);
        to_pos(13);
        step(1'b0, 1'b1, 16'h7777);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 16'h3333);
        idle(70);
        // Random traffic
        for (int k = 0; k < 900; k++) begin
            if ($urandom_range(15) == 0) mask = N'($urandom);
            if ($urandom_range(7) == 0) mask = '0;
            if ($urandom_range(299) == 0)
                step(1'b0, 1'($urandom), 16'($urandom));
            else
                step(1'b1, $urandom_range(9) == 0, 16'($urandom));
        end
        idle(4);
        wait_cnt = 0;
        while (q.size() != 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain queue left %0d want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
